// File: rtl/maxterm_extractor_pkg.sv
// maxterm_extractor_pkg: shared state encoding, mode codes and default width
package maxterm_extractor_pkg;
    typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;
    localparam logic MODE_MAX = 1'b0;
    localparam logic MODE_MIN = 1'b1;
    localparam int NVARS_DEF = 4;
endpackage

// File: rtl/maxterm_extractor_if.sv
// maxterm_extractor_if: request, status and term-stream signals of the extractor
interface maxterm_extractor_if
    import maxterm_extractor_pkg::*;
#(parameter int NVARS = NVARS_DEF);
    localparam int NTERMS = 2 ** NVARS;
    logic              start;
    logic [NTERMS-1:0] table_in;
    logic              mode;
    logic              busy;
    logic              term_valid;
    logic              term_ready;
    logic [NVARS-1:0]  term_idx;
    logic              term_last;
    logic              done;
    logic [NVARS:0]    count;
    modport master (output start, table_in, mode, term_ready,
                    input  busy, term_valid, term_idx, term_last, done, count);
    modport slave  (input  start, table_in, mode, term_ready,
                    output busy, term_valid, term_idx, term_last, done, count);
endinterface

// File: rtl/maxterm_extractor.sv
// maxterm_extractor: scans a captured truth table and streams matching term indices in ascending order
module maxterm_extractor
    import maxterm_extractor_pkg::*;
#(parameter int NVARS = NVARS_DEF)
(
    input logic                clk,
    input logic                rst_n,
    maxterm_extractor_if.slave bus
);
    localparam int NTERMS = 2 ** NVARS;
    state_t            state, state_n;
    logic [NTERMS-1:0] tbl, m, above;
    logic              md, hit, at_end, xfer;
    logic [NVARS-1:0]  idx;
    logic [NVARS:0]    cnt;
    assign m      = (md == MODE_MIN) ? tbl : ~tbl;
    assign hit    = m[idx];
    assign at_end = &idx;
    assign xfer   = (state == EMIT) && bus.term_ready;
    // matching bits strictly above the current index decide term_last
    assign above  = (m >> idx) >> 1;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_n;
    always_comb begin
        state_n = state == IDLE ? (bus.start ? SCAN : IDLE) :
                  state == SCAN ? (hit ? EMIT : at_end ? DONE : SCAN) :
                  state == EMIT ? (xfer ? (at_end ? DONE : SCAN) : EMIT) : IDLE;
        bus.busy       = state != IDLE;
        bus.term_valid = state == EMIT;
        bus.term_idx   = idx;
        bus.term_last  = (state == EMIT) && ~|above;
        bus.done       = state == DONE;
        bus.count      = cnt;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            tbl <= '0;
            md  <= 1'b0;
            idx <= '0;
            cnt <= '0;
        end else begin
            if (state == IDLE && bus.start) begin
                tbl <= bus.table_in;
                md  <= bus.mode;
                idx <= '0;
                cnt <= '0;
            end
            if ((state == SCAN && !hit && !at_end) || (xfer && !at_end)) idx <= idx + 1'b1;
            if (xfer) cnt <= cnt + 1'b1;
        end
endmodule

// File: tb/tb_maxterm_extractor.sv
// tb_maxterm_extractor: directed scans with hand-computed term lists, latencies and reset behaviour
module tb_maxterm_extractor;
    import maxterm_extractor_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   q_max[$] = '{0, 1, 2, 4, 6, 8, 12, 14};
    int   q_min[$] = '{3, 5, 7, 9, 10, 11, 13, 15};
    int   q_none[$];
    int   q_all[$];
    always #5 clk = ~clk;
    maxterm_extractor_if #(.NVARS(4)) bus();
    maxterm_extractor #(.NVARS(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_valid"}, bus.term_valid, 0);
        check({tag, "_idx"}, bus.term_idx, 0);
        check({tag, "_last"}, bus.term_last, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_count"}, bus.count, 0);
    endtask

    task automatic run(input logic [15:0] tbl, input logic md, input logic toggle,
                       input int exp[$], input int cyc, input int inj, input int rst_at);
        int   got[$];
        int   n, lasts, lastpos;
        logic rdy, pv, plast;
        logic [3:0] pidx;
        lasts = 0; lastpos = -1; rdy = 1'b0; pv = 1'b0; plast = 1'b0; pidx = '0;
        bus.table_in = tbl;
        bus.mode = md;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (n = 1; n <= 200; n++) begin
            @(negedge clk);
            bus.start = (n == inj);
            if (n == inj) begin
                bus.table_in = ~tbl;
                bus.mode = ~md;
            end
            if (bus.done) break;
            if (rst_at >= 0 && bus.term_valid && got.size() == rst_at) begin
                check("rst_pre_idx", bus.term_idx, exp[rst_at]);
                rst_n = 1'b0;
                #1 check_zero("rst_mid");
                repeat (3) begin
                    @(negedge clk);
                    check("rst_no_done", bus.done, 0);
                end
                rst_n = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    check("rst_wait_idle", bus.busy, 0);
                end
                return;
            end
            if (pv) begin
                check("hold_valid", bus.term_valid, 1);
                check("hold_idx", bus.term_idx, pidx);
                check("hold_last", bus.term_last, plast);
            end
            rdy = toggle ? ~rdy : 1'b1;
            bus.term_ready = rdy;
            if (bus.term_valid && rdy) begin
                got.push_back(int'(bus.term_idx));
                if (bus.term_last) begin
                    lasts++;
                    lastpos = got.size() - 1;
                end
            end
            pv = bus.term_valid && !rdy;
            pidx = bus.term_idx;
            plast = bus.term_last;
        end
        if (n > 200) check("timeout", 0, 1);
        check("count", bus.count, exp.size());
        check("busy_at_done", bus.busy, 1);
        if (cyc >= 0) check("latency", n, cyc);
        check("nterms", got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) check("term", got[i], exp[i]);
        check("last_cnt", lasts, exp.size() > 0 ? 1 : 0);
        if (exp.size() > 0) check("last_pos", lastpos, exp.size() - 1);
        @(negedge clk);
        check("done_pulse", bus.done, 0);
        check("busy_after", bus.busy, 0);
        check("count_hold", bus.count, exp.size());
    endtask

    initial begin
        bus.start = 1'b0;
        bus.table_in = '0;
        bus.mode = 1'b0;
        bus.term_ready = 1'b0;
        for (int i = 0; i < 16; i++) q_all.push_back(i);
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        run(16'hAEA8, MODE_MAX, 1'b0, q_max, 25, -1, -1);
        run(16'hAEA8, MODE_MIN, 1'b1, q_min, -1, -1, -1);
        run(16'hFFFF, MODE_MAX, 1'b0, q_none, 17, -1, -1);
        run(16'h0000, MODE_MAX, 1'b0, q_all, 33, -1, -1);
        run(16'hAEA8, MODE_MAX, 1'b0, q_max, 25, 5, -1);
        run(16'hAEA8, MODE_MIN, 1'b0, q_min, -1, -1, 2);
        run(16'hAEA8, MODE_MIN, 1'b0, q_min, 25, -1, -1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/maxterm_extractor.md
MAXTERM_EXTRACTOR -- requirements
Module: maxterm_extractor

Interface
REQ-001 SHALL have parameter NVARS, default 4, number of function variables; legal range 2..6.
REQ-002 SHALL have derived constant NTERMS = 2**NVARS, the truth-table width; it is not user-settable.
REQ-003 clk  in  1  rising-edge clock; all state changes occur on this edge.
REQ-004 rst_n  in  1  reset, asynchronous assert and active-low.
REQ-005 start  in  1  request to capture table_in and mode and begin a scan.
REQ-006 table_in  in  NTERMS  truth table; bit i is f(i), where index i = {X,Y,W,Z} with X as MSB.
REQ-007 mode  in  1  0 = list maxterms (f=0); 1 = list minterms (f=1).
REQ-008 busy  out  1  high from the cycle after start is accepted until the done cycle inclusive.
REQ-009 term_valid  out  1  term_idx holds a valid term index.
REQ-010 term_ready  in  1  consumer accepts the term; a transfer occurs when term_valid and term_ready are both high.
REQ-011 term_idx  out  NVARS  index of the emitted term.
REQ-012 term_last  out  1  qualifies term_valid; high when no matching index above term_idx remains.
REQ-013 done  out  1  one-cycle pulse at the end of a scan.
REQ-014 count  out  NVARS+1  number of terms transferred in the current or last scan.

Function
REQ-015 SHALL implement a state machine with states IDLE, SCAN, EMIT and DONE.
REQ-016 IDLE: when start=1, SHALL register table_in and mode, clear count, set scan index to 0, and go to SCAN.
REQ-017 SCAN: SHALL examine one index per cycle; the index matches when the stored bit equals mode.
REQ-018 SCAN, match: SHALL go to EMIT with term_idx = index, so term_valid is high in the next cycle.
REQ-019 SCAN, no match: SHALL advance the index; if the index is NTERMS-1, SHALL go to DONE instead.
REQ-020 EMIT: term_valid, term_idx and term_last SHALL hold stable until the transfer occurs.
REQ-021 EMIT, on transfer: SHALL increment count, then go to DONE if the index is NTERMS-1, otherwise go to SCAN with index+1.
REQ-022 DONE: SHALL assert done for exactly one cycle, then go to IDLE; count SHALL hold until the next accepted start.
REQ-023 start SHALL be ignored while busy=1; table_in and mode changes after capture SHALL have no effect on the scan.
REQ-024 SHALL emit terms in strictly ascending index order, each exactly once.
REQ-025 Latency with term_ready held high: done SHALL occur exactly 16 + N + 1 cycles after start is sampled, where N is the number of terms (NVARS=4).
REQ-026 Empty result (no matching index): term_valid SHALL never assert, and count SHALL be 0 at done.
REQ-027 Full result (all 16 indices match): SHALL emit 16 terms, and count SHALL be 16 with no wrap-around.
REQ-028 term_last SHALL be computed from the stored table bits above the current index, and SHALL be high on exactly one term per non-empty scan.

Reset
REQ-029 On rst_n=0: state SHALL be IDLE and every output 0 (busy, term_valid, term_idx, term_last, done, count).
REQ-030 Reset mid-scan SHALL abort the scan with no done pulse; after release, the block SHALL wait for a new start.

Structure
REQ-031 A shared package SHALL hold the state enum, the constants MODE_MAX=0 and MODE_MIN=1, and the default NVARS.
REQ-032 The design SHALL be a single module with no sub-module; term_last is a masked OR-reduction inside it.

Verification
REQ-033 table_in=16'hAEA8, mode=0, ready=1 -> terms 0,1,2,4,6,8,12,14; last on 14; count=8; done 25 cycles after start.
REQ-034 table_in=16'hAEA8, mode=1, ready toggled each cycle -> terms 3,5,7,9,10,11,13,15; each stable while stalled; count=8.
REQ-035 table_in=16'hFFFF, mode=0 -> no term_valid; done 17 cycles after start; count=0. table_in=16'h0000, mode=0 -> 16 terms 0..15; count=16; last on 15.
REQ-036 start pulsed again mid-scan, with table_in changed -> ignored; the original sequence completes unchanged.
REQ-037 rst_n low during EMIT of the 3rd term -> all outputs 0 at once, no done; a new start then gives a full correct scan.
